// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave = arbiter side, master = requesters plus memory.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              core_stall;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_q,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_address, mem_data, mem_rden, mem_wren,
    output core_stall
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_q,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_address, mem_data, mem_rden, mem_wren,
    input  core_stall
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory; read data is routed back by tag.
// ARB_ROUND_ROBIN_EN swaps fixed priority + starvation counter for round-robin.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);
  logic              gnt0, gnt1, gnt_any, issue_we, issue_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata0_q, rdata1_q;
  logic [RD_LAT:1]   vld_pipe, port_pipe;
  logic              rv0, rv1;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 means port 1 won last, so port 0 takes the first conflict after reset.
  logic last_winner;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        gnt0 = last_winner;
        gnt1 = ~last_winner;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          last_winner <= 1'b1;
    else if (gnt_any) last_winner <= gnt1;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        gnt1 = starved;
        gnt0 = ~starved;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (bus.p1_req && !gnt1) begin
      if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
    end else
      starve_cnt <= '0;
  end
`endif

  assign gnt_any  = gnt0 | gnt1;
  assign issue_we = gnt1 ? bus.p1_we : bus.p0_we;
  assign issue_rd = gnt_any & ~issue_we;

  assign bus.p0_gnt     = gnt0;
  assign bus.p1_gnt     = gnt1;
  assign bus.core_stall = bus.p0_req & ~gnt0;

  // Idle cycles keep the last issued address/data on the memory pins.
  assign bus.mem_address = !gnt_any ? addr_q : (gnt1 ? bus.p1_addr  : bus.p0_addr);
  assign bus.mem_data    = !gnt_any ? data_q : (gnt1 ? bus.p1_wdata : bus.p0_wdata);
  assign bus.mem_wren    = gnt_any & issue_we;
  assign bus.mem_rden    = issue_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (gnt_any) begin
      addr_q <= bus.mem_address;
      data_q <= bus.mem_data;
    end
  end

  // Read tags travel alongside the memory latency; exit stage RD_LAT lines up with mem_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue_rd;
      port_pipe[1] <= gnt1;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        port_pipe[i] <= port_pipe[i-1];
      end
    end
  end

  assign rv0 = ~rst & vld_pipe[RD_LAT] & ~port_pipe[RD_LAT];
  assign rv1 = ~rst & vld_pipe[RD_LAT] &  port_pipe[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rv0) rdata0_q <= bus.mem_q;
      if (rv1) rdata1_q <= bus.mem_q;
    end
  end

  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_rdata  = rv0 ? bus.mem_q : rdata0_q;
  assign bus.p1_rdata  = rv1 ? bus.mem_q : rdata1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized + directed bench for dmem_port_arbiter against a transaction-level model.
module tb_dmem_port_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural memory: registered read, RD_LAT cycles to mem_q.
  logic [DATA_W-1:0] tmem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] qpipe [RD_LAT];
  assign bus.mem_q = qpipe[RD_LAT-1];
  always @(posedge clk) begin
    if (bus.mem_wren) tmem[bus.mem_address] <= bus.mem_data;
    if (bus.mem_rden) qpipe[0] <= tmem[bus.mem_address];
    for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
  end

  typedef struct {
    int                due;
    bit                port;
    logic [DATA_W-1:0] data;
  } ret_t;

  int                n_run = 0, n_fail = 0, cyc = 0, streak = 0;
  bit                last_rr = 1'b1, g0, g1, have_last;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] exp_rd [2];
  ret_t              rq [$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock of model + checks; inputs are already driven for this cycle.
  task automatic cycle();
    bit                e0, e1, we, rv0, rv1;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    ret_t              r;
    #4;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        e0 = last_rr;
`else
        e0 = (streak != STARVE_MAX);
`endif
        e1 = !e0;
      end else begin
        e0 = bus.p0_req;
        e1 = bus.p1_req;
      end
    end
    we = e1 ? bus.p1_we : bus.p0_we;
    a  = e1 ? bus.p1_addr : bus.p0_addr;
    d  = e1 ? bus.p1_wdata : bus.p0_wdata;
    chk("p0_gnt", bus.p0_gnt, e0);
    chk("p1_gnt", bus.p1_gnt, e1);
    chk("core_stall", bus.core_stall, bus.p0_req && !e0);
    chk("mem_wren", bus.mem_wren, (e0 || e1) && we);
    chk("mem_rden", bus.mem_rden, (e0 || e1) && !we);
    if (e0 || e1) chk("mem_address", bus.mem_address, a);
    if ((e0 || e1) && we) chk("mem_data", bus.mem_data, d);
    if (!rst && !(e0 || e1) && have_last) begin
      chk("idle_address", bus.mem_address, last_a);
      chk("idle_data", bus.mem_data, last_d);
    end
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].port) rv1 = 1'b1; else rv0 = 1'b1;
      exp_rd[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("p0_rvalid", bus.p0_rvalid, rv0);
    chk("p1_rvalid", bus.p1_rvalid, rv1);
    chk("p0_rdata", bus.p0_rdata, exp_rd[0]);
    chk("p1_rdata", bus.p1_rdata, exp_rd[1]);
    g0 = e0;
    g1 = e1;
    @(posedge clk);
    if (rst) begin
      rq.delete();
      streak    = 0;
      last_rr   = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      have_last = 1'b0;
    end else begin
      if (e0 || e1) begin
        if (we) ref_mem[int'(a)] = d;
        else begin
          r.due  = cyc + RD_LAT;
          r.port = e1;
          r.data = ref_mem[int'(a)];
          rq.push_back(r);
        end
        last_rr   = e1;
        last_a    = a;
        last_d    = d;
        have_last = 1'b1;
      end
      if (bus.p1_req && !e1) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
      else streak = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic drive0(bit r, bit w, int a, logic [DATA_W-1:0] d);
    bus.p0_req = r; bus.p0_we = w; bus.p0_addr = ADDR_W'(a); bus.p0_wdata = d;
  endtask

  task automatic drive1(bit r, bit w, int a, logic [DATA_W-1:0] d);
    bus.p1_req = r; bus.p1_we = w; bus.p1_addr = ADDR_W'(a); bus.p1_wdata = d;
  endtask

  initial begin
    int a0, a1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    have_last = 1'b0;
    rst = 1'b1;
    a0 = 0;
    a1 = 32;
    drive0(1, 1, a0, $urandom);
    drive1(1, 1, a1, $urandom);
    @(posedge clk); #1;
    repeat (3) cycle();
    rst = 1'b0;

    // Contention: both write continuously, each steps its address when granted.
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (g0) begin a0++; drive0(1, 1, a0, $urandom); end
      if (g1) begin a1++; drive1(1, 1, a1, $urandom); end
    end

    // Preload every address used below through the loader port.
    drive0(0, 0, 0, '0);
    for (int i = 0; i < 64; i++) begin
      drive1(1, 1, i, $urandom);
      cycle();
    end
    drive1(0, 0, 0, '0);

    // Write then read the same word back-to-back.
    drive0(1, 1, 'h010, 32'hDEADBEEF);
    cycle();
    drive0(1, 0, 'h010, '0);
    cycle();
    drive0(0, 0, 0, '0);
    repeat (RD_LAT + 1) cycle();

    // Loader read followed by core read: returns in issue order.
    drive1(1, 0, 'h020, '0);
    cycle();
    drive1(0, 0, 0, '0);
    drive0(1, 0, 'h030, '0);
    cycle();
    drive0(0, 0, 0, '0);
    repeat (RD_LAT + 1) cycle();

    // Reset right behind a read: its return must be dropped.
    drive0(1, 0, 'h010, '0);
    cycle();
    drive0(0, 0, 0, '0);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (RD_LAT + 3) cycle();

    // Random traffic; requesters hold their fields until granted.
    for (int i = 0; i < 500; i++) begin
      if (!bus.p0_req || g0)
        drive0($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
      if (!bus.p1_req || g1)
        drive1($urandom_range(0, 99) < 50, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    drive0(0, 0, 0, '0);
    drive1(0, 0, 0, '0);
    repeat (RD_LAT + 2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
